// File: rtl/wd_host_driver.sv
// Host-side stimulus/capture engine for the WD core: replays one configured
// frame onto the WD input stream, then buffers the WD reply for readback.
module wd_host_driver #(
  parameter int SEND_LEN  = 8,
  parameter int MAX_BEATS = 10,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [4:0]  cfg_wdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        overflow,
  output logic        proto_err,
  output logic        in_valid,
  output logic [4:0]  keyboard,
  output logic [4:0]  answer,
  output logic [3:0]  weight,
  output logic [2:0]  match_target,
  input  logic        out_valid,
  input  logic [4:0]  result,
  input  logic [10:0] out_value,
  output logic [3:0]  beat_count,
  input  logic [3:0]  rd_idx,
  output logic [4:0]  rd_result,
  output logic [10:0] rd_value
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    LAST_IDX = 4'(SEND_LEN - 1);
  localparam logic [3:0]    MAX_CNT  = 4'(MAX_BEATS);
  localparam logic [TW-1:0] TO_CNT   = TW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      send_idx_q, send_idx_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]      beat_count_q, beat_count_d;
  logic            timeout_q, timeout_d;
  logic            overflow_q, overflow_d;
  logic            proto_err_q, proto_err_d;
  logic            in_valid_q, in_valid_d;
  logic [4:0]      keyboard_q, keyboard_d;
  logic [4:0]      answer_q, answer_d;
  logic [3:0]      weight_q, weight_d;
  logic [2:0]      match_target_q, match_target_d;

  // Frame registers (not reset)
  logic [7:0][4:0] kb_q, kb_d;
  logic [4:0][4:0] ans_q, ans_d;
  logic [4:0][3:0] wt_q, wt_d;
  logic [1:0][2:0] mt_q, mt_d;

  logic [4:0]      buf_res_q [MAX_BEATS];
  logic [10:0]     buf_val_q [MAX_BEATS];

  logic            buf_we;
  logic            load_beat;
  logic [3:0]      load_idx;
  logic [4:0]      cfg_off;

  always_comb begin
    state_d        = state_q;
    send_idx_d     = send_idx_q;
    wait_cnt_d     = wait_cnt_q;
    beat_count_d   = beat_count_q;
    timeout_d      = timeout_q;
    overflow_d     = overflow_q;
    proto_err_d    = proto_err_q;
    in_valid_d     = 1'b0;
    keyboard_d     = '0;
    answer_d       = '0;
    weight_d       = '0;
    match_target_d = '0;
    kb_d           = kb_q;
    ans_d          = ans_q;
    wt_d           = wt_q;
    mt_d           = mt_q;
    buf_we         = 1'b0;
    load_beat      = 1'b0;
    load_idx       = '0;
    cfg_off        = '0;

    if (cfg_we && state_q == S_IDLE) begin
      if (cfg_addr < 5'd8) begin
        kb_d[cfg_addr[2:0]] = cfg_wdata;
      end else if (cfg_addr < 5'd13) begin
        cfg_off = cfg_addr - 5'd8;
        ans_d[cfg_off[2:0]] = cfg_wdata;
      end else if (cfg_addr < 5'd18) begin
        cfg_off = cfg_addr - 5'd13;
        wt_d[cfg_off[2:0]] = cfg_wdata[3:0];
      end else if (cfg_addr < 5'd20) begin
        mt_d[cfg_addr[0]] = cfg_wdata[2:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SEND;
          send_idx_d   = '0;
          beat_count_d = '0;
          timeout_d    = 1'b0;
          overflow_d   = 1'b0;
          proto_err_d  = 1'b0;
          load_beat    = 1'b1;
          load_idx     = '0;
        end
      end
      S_SEND: begin
        // A reply while we are still sending is a protocol violation; drop it
        if (out_valid) proto_err_d = 1'b1;
        if (send_idx_q == LAST_IDX) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end else begin
          send_idx_d = send_idx_q + 4'd1;
          load_beat  = 1'b1;
          load_idx   = send_idx_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (out_valid) begin
          buf_we       = 1'b1;
          beat_count_d = beat_count_q + 4'd1;
          state_d      = S_RECV;
        end else if (wait_cnt_q == TO_CNT) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_RECV: begin
        if (out_valid) begin
          if (beat_count_q == MAX_CNT) begin
            overflow_d = 1'b1;
          end else begin
            buf_we       = 1'b1;
            beat_count_d = beat_count_q + 4'd1;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Frame slots beyond the configured depth of each field drive zero
    if (load_beat) begin
      in_valid_d = 1'b1;
      if (load_idx < 4'd8) keyboard_d = kb_q[load_idx[2:0]];
      if (load_idx < 4'd5) begin
        answer_d = ans_q[load_idx[2:0]];
        weight_d = wt_q[load_idx[2:0]];
      end
      if (load_idx < 4'd2) match_target_d = mt_q[load_idx[0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      send_idx_q     <= '0;
      wait_cnt_q     <= '0;
      beat_count_q   <= '0;
      timeout_q      <= 1'b0;
      overflow_q     <= 1'b0;
      proto_err_q    <= 1'b0;
      in_valid_q     <= 1'b0;
      keyboard_q     <= '0;
      answer_q       <= '0;
      weight_q       <= '0;
      match_target_q <= '0;
    end else begin
      state_q        <= state_d;
      send_idx_q     <= send_idx_d;
      wait_cnt_q     <= wait_cnt_d;
      beat_count_q   <= beat_count_d;
      timeout_q      <= timeout_d;
      overflow_q     <= overflow_d;
      proto_err_q    <= proto_err_d;
      in_valid_q     <= in_valid_d;
      keyboard_q     <= keyboard_d;
      answer_q       <= answer_d;
      weight_q       <= weight_d;
      match_target_q <= match_target_d;
    end
  end

  always_ff @(posedge clk) begin
    kb_q  <= kb_d;
    ans_q <= ans_d;
    wt_q  <= wt_d;
    mt_q  <= mt_d;
  end

  always_ff @(posedge clk) begin
    if (buf_we && !rst) begin
      buf_res_q[beat_count_q] <= result;
      buf_val_q[beat_count_q] <= out_value;
    end
  end

  assign busy         = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_RECV);
  assign done         = (state_q == S_DONE);
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
  assign proto_err    = proto_err_q;
  assign in_valid     = in_valid_q;
  assign keyboard     = keyboard_q;
  assign answer       = answer_q;
  assign weight       = weight_q;
  assign match_target = match_target_q;
  assign beat_count   = beat_count_q;
  assign rd_result    = (rd_idx < MAX_CNT) ? buf_res_q[rd_idx] : '0;
  assign rd_value     = (rd_idx < MAX_CNT) ? buf_val_q[rd_idx] : '0;

endmodule

// File: tb/tb_wd_host_driver.sv
// Directed bench for wd_host_driver with a simple WD reply model.
module tb_wd_host_driver;
  localparam int SL = 8;
  localparam int MB = 10;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst, cfg_we, start, out_valid;
  logic [4:0]  cfg_addr, cfg_wdata, result;
  logic [10:0] out_value;
  logic [3:0]  rd_idx;
  logic        busy, done, timeout, overflow, proto_err, in_valid;
  logic [4:0]  keyboard, answer;
  logic [3:0]  weight;
  logic [2:0]  match_target;
  logic [3:0]  beat_count;
  logic [4:0]  rd_result;
  logic [10:0] rd_value;

  int nvec = 0;
  int nerr = 0;

  logic [4:0] exp_kb  [8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
  logic [4:0] exp_ans [8] = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd0, 5'd0, 5'd0};
  logic [3:0] exp_wt  [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0};
  logic [2:0] exp_mt  [8] = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

  logic [4:0] obs_kb  [8];
  logic [4:0] obs_ans [8];
  logic [3:0] obs_wt  [8];
  logic [2:0] obs_mt  [8];
  int   iv_cnt, first_iv, done_cnt, done_w;
  logic busy_at_done, done_after;

  wd_host_driver #(.SEND_LEN(SL), .MAX_BEATS(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy), .done(done), .timeout(timeout), .overflow(overflow),
    .proto_err(proto_err), .in_valid(in_valid), .keyboard(keyboard), .answer(answer),
    .weight(weight), .match_target(match_target), .out_valid(out_valid), .result(result),
    .out_value(out_value), .beat_count(beat_count), .rd_idx(rd_idx),
    .rd_result(rd_result), .rd_value(rd_value)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [4:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  // One full transaction; the WD model replies nb beats starting at WAIT cycle
  // 'delay' (negative: never), and pulses out_valid during SEND beat pv.
  task automatic run_txn(input int delay, input int nb, input int pv, input int vbase, input bit poke);
    int  w;
    logic ov;
    iv_cnt = 0; first_iv = -1; done_cnt = 0; done_w = -1; busy_at_done = 1'bx; w = 0;
    for (int k = 0; k < 8; k++) begin
      obs_kb[k] = 'x; obs_ans[k] = 'x; obs_wt[k] = 'x; obs_mt[k] = 'x;
    end
    start = 1'b1;
    step();
    for (int c = 1; c < 300 && done_cnt == 0; c++) begin
      ov = 1'b0; cfg_we = 1'b0; start = 1'b0;
      if (in_valid === 1'b1) begin
        if (iv_cnt < 8) begin
          obs_kb[iv_cnt] = keyboard; obs_ans[iv_cnt] = answer;
          obs_wt[iv_cnt] = weight;   obs_mt[iv_cnt] = match_target;
        end
        if (iv_cnt == pv) begin ov = 1'b1; result = 5'd31; out_value = 11'd2047; end
        if (poke && iv_cnt == 2) begin
          cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 5'd31; start = 1'b1;
        end
        if (first_iv < 0) first_iv = c;
        iv_cnt++;
      end else if (iv_cnt >= SL) begin
        if (delay >= 0 && w >= delay && w < delay + nb) begin
          ov = 1'b1; result = 5'(w - delay); out_value = 11'(vbase + w - delay);
        end
        if (done === 1'b1) begin done_cnt++; done_w = w; busy_at_done = busy; end
        w++;
      end
      out_valid = ov;
      step();
    end
    out_valid = 1'b0; cfg_we = 1'b0; start = 1'b0;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    out_valid = 1'b0; result = '0; out_value = '0; rd_idx = '0;
    step(); step();
    nvec++;
    if ({in_valid, busy, done, timeout, overflow, proto_err} !== 6'b0) begin
      nerr++; $display("FAIL reset_ctrl got %b required 000000", {in_valid, busy, done, timeout, overflow, proto_err});
    end
    nvec++;
    if ({keyboard, answer, weight, match_target, beat_count} !== 21'b0) begin
      nerr++; $display("FAIL reset_data got kb=%0d ans=%0d wt=%0d mt=%0d bc=%0d required all 0",
                       keyboard, answer, weight, match_target, beat_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic program_frame();
    for (int k = 0; k < 8; k++) wr(5'(k), exp_kb[k]);
    for (int k = 0; k < 5; k++) wr(5'(8 + k), exp_ans[k]);
    for (int k = 0; k < 5; k++) wr(5'(13 + k), {1'b0, exp_wt[k]});
    for (int k = 0; k < 2; k++) wr(5'(18 + k), {2'b0, exp_mt[k]});
    wr(5'd25, 5'd17);
  endtask

  task automatic test_happy();
    run_txn(2, 10, -1, 100, 1'b0);
    nvec++;
    if (iv_cnt != 8 || first_iv != 1) begin
      nerr++; $display("FAIL happy_in_valid got count=%0d first=%0d required count=8 first=1", iv_cnt, first_iv);
    end
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if ({obs_kb[k], obs_ans[k], obs_wt[k], obs_mt[k]} !== {exp_kb[k], exp_ans[k], exp_wt[k], exp_mt[k]}) begin
        nerr++; $display("FAIL happy_beat%0d got kb=%0d ans=%0d wt=%0d mt=%0d required kb=%0d ans=%0d wt=%0d mt=%0d",
                         k, obs_kb[k], obs_ans[k], obs_wt[k], obs_mt[k], exp_kb[k], exp_ans[k], exp_wt[k], exp_mt[k]);
      end
    end
    nvec++;
    if (done_cnt != 1 || busy_at_done !== 1'b0 || done_after !== 1'b0) begin
      nerr++; $display("FAIL happy_done got pulses=%0d busy=%b next=%b required 1 0 0", done_cnt, busy_at_done, done_after);
    end
    nvec++;
    if (beat_count !== 4'd10) begin
      nerr++; $display("FAIL happy_beat_count got %0d required 10", beat_count);
    end
    rd_idx = 4'd9; #1;
    nvec++;
    if (rd_result !== 5'd9 || rd_value !== 11'd109) begin
      nerr++; $display("FAIL happy_rd9 got %0d/%0d required 9/109", rd_result, rd_value);
    end
    rd_idx = 4'd0; #1;
    nvec++;
    if (rd_result !== 5'd0 || rd_value !== 11'd100) begin
      nerr++; $display("FAIL happy_rd0 got %0d/%0d required 0/100", rd_result, rd_value);
    end
    nvec++;
    if ({timeout, overflow, proto_err} !== 3'b000) begin
      nerr++; $display("FAIL happy_flags got %b required 000", {timeout, overflow, proto_err});
    end
  endtask

  task automatic test_immediate();
    run_txn(0, 3, -1, 200, 1'b0);
    nvec++;
    if (beat_count !== 4'd3 || proto_err !== 1'b0 || done_cnt != 1) begin
      nerr++; $display("FAIL immediate got bc=%0d perr=%b done=%0d required 3 0 1", beat_count, proto_err, done_cnt);
    end
    rd_idx = 4'd2; #1;
    nvec++;
    if (rd_result !== 5'd2 || rd_value !== 11'd202) begin
      nerr++; $display("FAIL immediate_rd2 got %0d/%0d required 2/202", rd_result, rd_value);
    end
    rd_idx = 4'd5; #1;
    nvec++;
    if (rd_result !== 5'd5 || rd_value !== 11'd105) begin
      nerr++; $display("FAIL immediate_stale5 got %0d/%0d required 5/105", rd_result, rd_value);
    end
  endtask

  task automatic test_timeout();
    run_txn(-1, 0, -1, 0, 1'b0);
    nvec++;
    if (done_cnt != 1 || done_w != 16) begin
      nerr++; $display("FAIL timeout_done got pulses=%0d at_wait=%0d required 1 16", done_cnt, done_w);
    end
    nvec++;
    if (timeout !== 1'b1 || beat_count !== 4'd0) begin
      nerr++; $display("FAIL timeout_flag got to=%b bc=%0d required 1 0", timeout, beat_count);
    end
  endtask

  task automatic test_overflow();
    run_txn(2, 12, -1, 300, 1'b0);
    nvec++;
    if (beat_count !== 4'd10 || overflow !== 1'b1 || timeout !== 1'b0) begin
      nerr++; $display("FAIL overflow got bc=%0d ovf=%b to=%b required 10 1 0", beat_count, overflow, timeout);
    end
    for (int n = 0; n < 10; n++) begin
      rd_idx = 4'(n); #1;
      nvec++;
      if (rd_result !== 5'(n) || rd_value !== 11'(300 + n)) begin
        nerr++; $display("FAIL overflow_buf%0d got %0d/%0d required %0d/%0d", n, rd_result, rd_value, n, 300 + n);
      end
    end
    rd_idx = 4'd10; #1;
    nvec++;
    if (rd_result !== 5'd0 || rd_value !== 11'd0) begin
      nerr++; $display("FAIL overflow_rd10 got %0d/%0d required 0/0", rd_result, rd_value);
    end
  endtask

  task automatic test_proto();
    run_txn(2, 2, 4, 400, 1'b0);
    nvec++;
    if (proto_err !== 1'b1 || done_cnt != 1 || overflow !== 1'b0 || beat_count !== 4'd2) begin
      nerr++; $display("FAIL proto got perr=%b done=%0d ovf=%b bc=%0d required 1 1 0 2",
                       proto_err, done_cnt, overflow, beat_count);
    end
    rd_idx = 4'd0; #1;
    nvec++;
    if (rd_result !== 5'd0 || rd_value !== 11'd400) begin
      nerr++; $display("FAIL proto_rd0 got %0d/%0d required 0/400", rd_result, rd_value);
    end
  endtask

  task automatic test_midreset();
    int bad;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    nvec++;
    if (in_valid !== 1'b1 || keyboard !== 5'd4) begin
      nerr++; $display("FAIL midreset_beat3 got iv=%b kb=%0d required 1 4", in_valid, keyboard);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++;
    if (in_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL midreset_abort got iv=%b busy=%b done=%b required 0 0 0", in_valid, busy, done);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (done !== 1'b0 || in_valid !== 1'b0) bad++;
      step();
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL midreset_quiet got %0d active cycles required 0", bad);
    end
    run_txn(2, 3, -1, 800, 1'b0);
    nvec++;
    if (iv_cnt != 8 || done_cnt != 1 || beat_count !== 4'd3) begin
      nerr++; $display("FAIL midreset_replay got iv=%0d done=%0d bc=%0d required 8 1 3", iv_cnt, done_cnt, beat_count);
    end
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if ({obs_kb[k], obs_ans[k], obs_wt[k], obs_mt[k]} !== {exp_kb[k], exp_ans[k], exp_wt[k], exp_mt[k]}) begin
        nerr++; $display("FAIL midreset_beat%0d got kb=%0d ans=%0d wt=%0d mt=%0d required kb=%0d ans=%0d wt=%0d mt=%0d",
                         k, obs_kb[k], obs_ans[k], obs_wt[k], obs_mt[k], exp_kb[k], exp_ans[k], exp_wt[k], exp_mt[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_txn(0, 1, -1, 500, 1'b0);
    run_txn(1, 1, -1, 600, 1'b0);
    nvec++;
    if (first_iv != 1 || iv_cnt != 8 || done_cnt != 1) begin
      nerr++; $display("FAIL b2b got first=%0d iv=%0d done=%0d required 1 8 1", first_iv, iv_cnt, done_cnt);
    end
    rd_idx = 4'd0; #1;
    nvec++;
    if (rd_value !== 11'd600) begin
      nerr++; $display("FAIL b2b_rd0 got %0d required 600", rd_value);
    end
  endtask

  task automatic test_guard();
    int bad;
    run_txn(2, 1, -1, 700, 1'b1);
    nvec++;
    if (iv_cnt != 8 || done_cnt != 1) begin
      nerr++; $display("FAIL guard_txn got iv=%0d done=%0d required 8 1", iv_cnt, done_cnt);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (in_valid !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL guard_no_restart got %0d busy cycles required 0", bad);
    end
    run_txn(2, 1, -1, 710, 1'b0);
    nvec++;
    if (obs_kb[0] !== 5'd1) begin
      nerr++; $display("FAIL guard_frame got kb0=%0d required 1", obs_kb[0]);
    end
  endtask

  initial begin
    test_reset();
    program_frame();
    test_happy();
    test_immediate();
    test_timeout();
    test_overflow();
    test_proto();
    test_midreset();
    test_back_to_back();
    test_guard();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
